teatris_unidade_controle: RTL and testbench
===========================================

Name: teatris_unidade_controle

Overview:
Control FSM for the TEAtris game. It drives the control inputs of teatris_fluxo_dados (counter, memory, jogada register, comparator, timer) and consumes that datapath's status outputs. It sequences each round: load the piece, wait for a play, register it, compare it, then advance, retry or end the game. It also reports game result and a debug state code.

Parameters:
MAX_ERROS, 1, wrong plays allowed before loss; legal range 1..15.
ERR_W, 4, width of the internal error counter.

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
iniciar  in  1  start/restart request, level-sampled
tem_jogada  in  1  datapath: a button press was detected
jogada_ok  in  1  datapath: registered jogada matches memory
fim_sequencia  in  1  datapath: counter at last address
timeout  in  1  datapath: play timer expired
zera_contador  out  1  clear address counter
conta_contador  out  1  increment address counter
enable_memoria  out  1  load current pattern from memory
registra_jogada  out  1  capture buttons into jogada register
compara_jogada  out  1  enable comparator
timer_restart  out  1  restart play timer
pronto  out  1  game over, result valid
ganhou  out  1  win
perdeu  out  1  loss (error limit or timeout)
db_estado  out  4  current state code

Behaviour:
- Moore FSM with a 4-bit state register. All control outputs decode from the state only, with no input-to-output combinational path.
- While reset=0 (asynchronous): state=INICIAL, error counter=0, all outputs 0, db_estado=0x0. Reset asserted mid-round aborts immediately; no pulse completes.
- States (db_estado code, asserted outputs, transitions):
  - INICIAL (0x0): no outputs. iniciar=1 -> PREPARA.
  - PREPARA (0x1): zera_contador, timer_restart. Clears the error counter. -> CARREGA.
  - CARREGA (0x2): enable_memoria, timer_restart. -> ESPERA.
  - ESPERA (0x3): no outputs. timeout=1 -> FIM_TIMEOUT. Else tem_jogada=1 -> REGISTRA. Else stay.
  - REGISTRA (0x4): registra_jogada. -> COMPARA.
  - COMPARA (0x5): compara_jogada. -> AVALIA.
  - AVALIA (0x6): no outputs. Samples jogada_ok and fim_sequencia.
    - ok and fim -> FIM_GANHOU.
    - ok and not fim -> PROXIMO.
    - not ok: error counter +1. If the new count reaches MAX_ERROS -> FIM_PERDEU, else -> CARREGA to retry the same piece.
  - PROXIMO (0x7): conta_contador. -> CARREGA.
  - FIM_GANHOU (0x8): pronto, ganhou.
  - FIM_PERDEU (0x9): pronto, perdeu.
  - FIM_TIMEOUT (0xA): pronto, perdeu.
  - From any FIM state, iniciar=1 -> PREPARA.
- Each control pulse lasts exactly 1 cycle. From tem_jogada sampled high in ESPERA to reaching AVALIA takes 3 cycles.
- Simultaneous timeout and tem_jogada in ESPERA: timeout wins.
- iniciar is ignored outside INICIAL and the FIM states.
- Error counter saturates at 2^ERR_W-1 and never wraps.
- Unused codes 0xB..0xF return to INICIAL on the next clock.

Optional Feature:
TEATRIS_TIMEOUT_EN
- Defined: behaviour exactly as above.
- Undefined: the timeout input is ignored. ESPERA leaves only on tem_jogada, FIM_TIMEOUT is unreachable, and timer_restart is still driven so the datapath stays unchanged.

Decomposition:
- Shared package teatris_pkg: state encodings (INICIAL..FIM_TIMEOUT), STATE_W=4, and the default MAX_ERROS. The datapath and the top level reuse these.
- No sub-module: the block is a single FSM plus the error counter.

Test Plan:
1. Reset low, then high with iniciar=0 -> db_estado=0x0, all outputs 0. Pulse iniciar -> zera_contador and timer_restart high together for 1 cycle, then enable_memoria for 1 cycle, then db_estado=0x3.
2. In ESPERA, pulse tem_jogada with jogada_ok=1, fim_sequencia=0 -> registra, compara, then conta_contador pulses in order, and the FSM returns to CARREGA/ESPERA.
3. Correct plays with fim_sequencia=1 at AVALIA -> db_estado=0x8, pronto=1, ganhou=1. iniciar -> PREPARA.
4. MAX_ERROS=2, two wrong plays -> first returns to CARREGA with no counter pulse; second gives db_estado=0x9 and perdeu=1.
5. timeout=1 and tem_jogada=1 in the same ESPERA cycle -> db_estado=0xA, perdeu=1. With TEATRIS_TIMEOUT_EN undefined -> REGISTRA instead.
6. Drive reset low while in COMPARA -> outputs 0 and db_estado=0x0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/teatris_pkg.sv
// ---------------------------------------------------------------------------
// teatris_pkg
// Definitions shared by the TEAtris control unit, its datapath and the top
// level: state register width, state codes (these are also the codes
// reported on db_estado) and the default wrong-play limit.
// No ports (package).
// ---------------------------------------------------------------------------
package teatris_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] INICIAL     = 4'h0;
    localparam logic [STATE_W-1:0] PREPARA     = 4'h1;
    localparam logic [STATE_W-1:0] CARREGA     = 4'h2;
    localparam logic [STATE_W-1:0] ESPERA      = 4'h3;
    localparam logic [STATE_W-1:0] REGISTRA    = 4'h4;
    localparam logic [STATE_W-1:0] COMPARA     = 4'h5;
    localparam logic [STATE_W-1:0] AVALIA      = 4'h6;
    localparam logic [STATE_W-1:0] PROXIMO     = 4'h7;
    localparam logic [STATE_W-1:0] FIM_GANHOU  = 4'h8;
    localparam logic [STATE_W-1:0] FIM_PERDEU  = 4'h9;
    localparam logic [STATE_W-1:0] FIM_TIMEOUT = 4'hA;

    localparam int MAX_ERROS_DEFAULT = 1;

    // True for the three game-over states, where iniciar restarts the game.
    function automatic logic is_fim(input logic [STATE_W-1:0] st);
        return (st == FIM_GANHOU) || (st == FIM_PERDEU) || (st == FIM_TIMEOUT);
    endfunction

endpackage

// File: rtl/teatris_unidade_controle_if.sv
// ---------------------------------------------------------------------------
// teatris_unidade_controle_if
// Bundle between the TEAtris control unit and its surroundings (user start
// request, datapath status in, datapath control out, game result, debug).
//   slave  : the control unit (consumes status, drives control/result)
//   master : the datapath / top level (drives status, consumes control)
// Signals:
//   iniciar, tem_jogada, jogada_ok, fim_sequencia, timeout   -> control unit
//   zera_contador, conta_contador, enable_memoria, registra_jogada,
//   compara_jogada, timer_restart, pronto, ganhou, perdeu,
//   db_estado[3:0]                                            <- control unit
// ---------------------------------------------------------------------------
interface teatris_unidade_controle_if;

    logic iniciar;
    logic tem_jogada;
    logic jogada_ok;
    logic fim_sequencia;
    logic timeout;

    logic zera_contador;
    logic conta_contador;
    logic enable_memoria;
    logic registra_jogada;
    logic compara_jogada;
    logic timer_restart;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic [teatris_pkg::STATE_W-1:0] db_estado;

    modport slave (
        input  iniciar, tem_jogada, jogada_ok, fim_sequencia, timeout,
        output zera_contador, conta_contador, enable_memoria, registra_jogada,
               compara_jogada, timer_restart, pronto, ganhou, perdeu, db_estado
    );

    modport master (
        output iniciar, tem_jogada, jogada_ok, fim_sequencia, timeout,
        input  zera_contador, conta_contador, enable_memoria, registra_jogada,
               compara_jogada, timer_restart, pronto, ganhou, perdeu, db_estado
    );

endinterface

// File: rtl/teatris_unidade_controle.sv
// ---------------------------------------------------------------------------
// teatris_unidade_controle
// Moore control FSM for the TEAtris game. Sequences each round (load piece,
// wait for a play, register, compare, then advance / retry / end) and keeps
// a saturating wrong-play counter.
// Ports:
//   clock : system clock (50 MHz)
//   reset : asynchronous, active-low
//   uc    : teatris_unidade_controle_if.slave (datapath status in, control
//           pulses, game result and db_estado out)
// Parameters:
//   MAX_ERROS : wrong plays allowed before loss (1..15)
//   ERR_W     : width of the wrong-play counter
// Build option:
//   TEATRIS_TIMEOUT_EN : when defined, the play timer's timeout ends the game
//                        from ESPERA (FIM_TIMEOUT); when undefined, timeout
//                        is ignored.
// ---------------------------------------------------------------------------
module teatris_unidade_controle
    import teatris_pkg::*;
#(
    parameter int MAX_ERROS = MAX_ERROS_DEFAULT,
    parameter int ERR_W     = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    teatris_unidade_controle_if.slave   uc
);

    localparam logic [ERR_W-1:0] LIMITE = ERR_W'(MAX_ERROS);

    logic [STATE_W-1:0] estado;
    logic [STATE_W-1:0] proximo;
    logic [ERR_W-1:0]   erros;
    logic [ERR_W-1:0]   erros_inc;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign erros_inc = sat_inc(erros);

`ifdef TEATRIS_TIMEOUT_EN
    logic fim_tempo;
    assign fim_tempo = uc.timeout;
`else
    logic fim_tempo;
    logic unused_timeout;
    assign fim_tempo      = 1'b0;
    assign unused_timeout = uc.timeout;
`endif

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:  proximo = uc.iniciar ? PREPARA : INICIAL;
            PREPARA:  proximo = CARREGA;
            CARREGA:  proximo = ESPERA;
            // timeout takes priority over a play arriving in the same cycle
            ESPERA: begin
                if (fim_tempo)            proximo = FIM_TIMEOUT;
                else if (uc.tem_jogada)   proximo = REGISTRA;
                else                      proximo = ESPERA;
            end
            REGISTRA: proximo = COMPARA;
            COMPARA:  proximo = AVALIA;
            AVALIA: begin
                if (uc.jogada_ok)
                    proximo = uc.fim_sequencia ? FIM_GANHOU : PROXIMO;
                else
                    // decision uses the count including this wrong play
                    proximo = (erros_inc >= LIMITE) ? FIM_PERDEU : CARREGA;
            end
            PROXIMO:  proximo = CARREGA;
            FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT:
                proximo = uc.iniciar ? PREPARA : estado;
            default:  proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            erros <= '0;
        end else if (estado == PREPARA) begin
            erros <= '0;
        end else if ((estado == AVALIA) && !uc.jogada_ok) begin
            erros <= erros_inc;
        end
    end

    // Outputs decode from the state register only.
    always_comb begin
        uc.zera_contador   = 1'b0;
        uc.conta_contador  = 1'b0;
        uc.enable_memoria  = 1'b0;
        uc.registra_jogada = 1'b0;
        uc.compara_jogada  = 1'b0;
        uc.timer_restart   = 1'b0;
        uc.pronto          = 1'b0;
        uc.ganhou          = 1'b0;
        uc.perdeu          = 1'b0;
        case (estado)
            PREPARA: begin
                uc.zera_contador = 1'b1;
                uc.timer_restart = 1'b1;
            end
            CARREGA: begin
                uc.enable_memoria = 1'b1;
                uc.timer_restart  = 1'b1;
            end
            REGISTRA: uc.registra_jogada = 1'b1;
            COMPARA:  uc.compara_jogada  = 1'b1;
            PROXIMO:  uc.conta_contador  = 1'b1;
            FIM_GANHOU: begin
                uc.pronto = 1'b1;
                uc.ganhou = 1'b1;
            end
            FIM_PERDEU, FIM_TIMEOUT: begin
                uc.pronto = 1'b1;
                uc.perdeu = 1'b1;
            end
            default: ;
        endcase
    end

    assign uc.db_estado = estado;

endmodule

// File: tb/tb_teatris_unidade_controle.sv
// ---------------------------------------------------------------------------
// tb_teatris_unidade_controle
// Bench for the TEAtris control unit (MAX_ERROS=2). A game-level reference
// model (round outcomes, wrong-play tally) predicts the state code seen each
// cycle; expected control outputs follow from the state table.
// ---------------------------------------------------------------------------
module tb_teatris_unidade_controle;

    localparam int MAX_E = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    teatris_unidade_controle_if bus();

    teatris_unidade_controle #(.MAX_ERROS(MAX_E), .ERR_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .uc    (bus)
    );

    int total = 0;
    int bad   = 0;
    int errs  = 0;
    bit over  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // {zera, conta, enable, registra, compara, timer_restart, pronto, ganhou, perdeu}
    function automatic logic [8:0] outs_for(input int code);
        case (code)
            1:       return 9'b1_0_0_0_0_1_0_0_0;
            2:       return 9'b0_0_1_0_0_1_0_0_0;
            4:       return 9'b0_0_0_1_0_0_0_0_0;
            5:       return 9'b0_0_0_0_1_0_0_0_0;
            7:       return 9'b0_1_0_0_0_0_0_0_0;
            8:       return 9'b0_0_0_0_0_0_1_1_0;
            9, 10:   return 9'b0_0_0_0_0_0_1_0_1;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [8:0] outs_seen();
        return {bus.zera_contador, bus.conta_contador, bus.enable_memoria,
                bus.registra_jogada, bus.compara_jogada, bus.timer_restart,
                bus.pronto, bus.ganhou, bus.perdeu};
    endfunction

    task automatic look(input int code);
        check_eq("estado", 32'(bus.db_estado), 32'(code));
        check_eq("saidas", 32'(outs_seen()), 32'(outs_for(code)));
    endtask

    task automatic step(input int code);
        @(posedge clock);
        #1;
        look(code);
    endtask

    // From INICIAL or a FIM state: request a game and follow it to ESPERA.
    task automatic start_game();
        bus.iniciar = 1'b1;
        step(1);
        bus.iniciar = 1'b0;
        step(2);
        step(3);
        errs = 0;
        over = 0;
    endtask

    // From ESPERA: idle cycles (noise on iniciar, ignored), then one play.
    task automatic play(input bit ok, input bit fim, input int idle);
        for (int i = 0; i < idle; i++) begin
            bus.tem_jogada = 1'b0;
            bus.iniciar    = 1'($urandom % 2);
`ifdef TEATRIS_TIMEOUT_EN
            bus.timeout    = 1'b0;
`else
            bus.timeout    = 1'($urandom % 2);
`endif
            step(3);
        end
        bus.timeout       = 1'b0;
        bus.tem_jogada    = 1'b1;
        bus.jogada_ok     = ok;
        bus.fim_sequencia = fim;
        bus.iniciar       = 1'($urandom % 2);
        step(4);
        bus.tem_jogada = 1'b0;
        bus.iniciar    = 1'b0;
        step(5);
        step(6);
        if (ok && fim) begin
            step(8);
            over = 1;
        end else if (ok) begin
            step(7);
            step(2);
            step(3);
        end else begin
            errs++;
            if (errs >= MAX_E) begin
                step(9);
                over = 1;
            end else begin
                step(2);
                step(3);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iniciar       = 1'b0;
        bus.tem_jogada    = 1'b0;
        bus.jogada_ok     = 1'b0;
        bus.fim_sequencia = 1'b0;
        bus.timeout       = 1'b0;

        // reset state
        #12;
        look(0);
        @(negedge clock);
        reset = 1'b1;
        step(0);
        step(0);

        // advance then win
        start_game();
        play(1'b1, 1'b0, 2);
        play(1'b1, 1'b1, 0);
        step(8);

        // two wrong plays -> loss
        start_game();
        play(1'b0, 1'b0, 1);
        play(1'b0, 1'b0, 0);
        step(9);

        // timeout and play in the same ESPERA cycle
        start_game();
        bus.timeout    = 1'b1;
        bus.tem_jogada = 1'b1;
`ifdef TEATRIS_TIMEOUT_EN
        step(10);
        bus.timeout    = 1'b0;
        bus.tem_jogada = 1'b0;
        step(10);
`else
        bus.jogada_ok     = 1'b1;
        bus.fim_sequencia = 1'b1;
        step(4);
        bus.tem_jogada = 1'b0;
        step(5);
        step(6);
        step(8);
        bus.timeout = 1'b0;
`endif

        // asynchronous reset while in COMPARA
        start_game();
        bus.tem_jogada    = 1'b1;
        bus.jogada_ok     = 1'b1;
        bus.fim_sequencia = 1'b0;
        step(4);
        bus.tem_jogada = 1'b0;
        step(5);
        #2;
        reset = 1'b0;
        #1;
        look(0);
        @(negedge clock);
        reset = 1'b1;
        step(0);

        // randomized games
        for (int g = 0; g < 30; g++) begin
            int n;
            start_game();
            n = 0;
            while (!over && n < 40) begin
`ifdef TEATRIS_TIMEOUT_EN
                if ($urandom % 8 == 0) begin
                    bus.timeout    = 1'b1;
                    bus.tem_jogada = 1'($urandom % 2);
                    step(10);
                    bus.timeout    = 1'b0;
                    bus.tem_jogada = 1'b0;
                    over = 1;
                end else
`endif
                play(($urandom % 3) != 0, ($urandom % 4) == 0, int'($urandom % 4));
                n++;
            end
            if (!over) begin
                reset = 1'b0;
                #1;
                look(0);
                @(negedge clock);
                reset = 1'b1;
                step(0);
            end else if ($urandom % 2 == 0) begin
                step(int'(bus.db_estado) == 8 ? 8 : (int'(bus.db_estado) == 9 ? 9 : 10));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
